dcache_wb: RTL and testbench
============================

# dcache_wb

Blocking, direct-mapped, write-back, write-allocate data cache between the pipeline's memory stage and the memory controller. Services the memory stage's load/store requests, raises `dhit` (the stall/flush qualifier consumed by the hazard unit) when a request completes, and fills from or writes back to memory on a miss. On `halt` it flushes every dirty frame to memory, optionally writes the hit count, then asserts `flushed`.

## Interface
- `NFRAMES`, 16: number of one-word frames (power of 2); index = `dmemaddr[IW+1:2]`, tag = `dmemaddr[31:IW+2]`, IW = log2(NFRAMES).
- `HITCNT_ADDR`, 32'h00003100: memory word address that receives the hit count.

- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `halt` in 1: processor halted; starts the flush.
- `dmemREN` in 1: pipeline load request.
- `dmemWEN` in 1: pipeline store request; never asserted together with `dmemREN`.
- `dmemaddr` in 32: request byte address; bits [1:0] are ignored.
- `dmemstore` in 32: store data.
- `dmemload` out 32: load data; valid while `dhit`.
- `dhit` out 1: the request completes this cycle.
- `flushed` out 1: flush finished; sticky until reset.
- `dREN` out 1: memory read request.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory word address, bits [1:0] = 0.
- `dstore` out 32: memory write data.
- `dload` in 32: memory read data.
- `dwait` in 1: memory busy; the access completes in the first cycle with `dwait`=0 while a request is held.

## Operation
- Each frame holds valid, dirty, tag and data. Reset clears valid and dirty in all frames; data and tag contents are don't-care.
- States:
  - IDLE: check for a hit.
  - WB: write back the victim.
  - FILL
  - FLUSH: scan the frames.
  - FLUSH_WB
  - CNT
  - DONE
- IDLE, read hit (valid and tag match): `dhit`=1 combinationally; `dmemload` = frame data.
- IDLE, write hit: `dhit`=1. At the clock edge, frame data ← `dmemstore` and dirty ← 1.
- IDLE, miss with victim dirty: go to WB.
  - `dWEN`=1, `daddr` = {victim tag, index, 2'b00}, `dstore` = victim data.
  - When `dwait`=0: clear dirty, go to FILL.
- IDLE, miss with victim clean: go directly to FILL.
- FILL: `dREN`=1, `daddr` = {`dmemaddr[31:2]`, 2'b00}. When `dwait`=0: frame ← {valid=1, dirty=0, tag, `dload`}, go to IDLE. The retried request then hits.
- Write miss: fill first, then the write hits in IDLE (write-allocate).
- `halt` in IDLE has priority over any request. It enters FLUSH with the scan index set to 0; `dhit`=0 from then on.
- FLUSH, scan index i:
  - Frame i valid and dirty: go to FLUSH_WB (same bus signals as WB). When `dwait`=0, clear dirty and return to FLUSH at i+1.
  - Frame i clean: advance i by one per cycle.
  - After index NFRAMES-1: go to CNT (see Configuration), else DONE.
- A `halt` that arrives during WB/FILL is honoured only after the access finishes and the state returns to IDLE.
- DONE: `flushed`=1 and no bus activity, held until reset.
- Hit counter (32-bit, wraps modulo 2^32):
  - Increments on each `dhit` cycle whose request did not miss.
  - A `missed` flag is set on leaving IDLE for WB/FILL and cleared on the next `dhit`.
- `dREN` and `dWEN` are never both 1.

## Timing
- Reset values:
  - `dhit`, `dREN`, `dWEN`, `flushed` = 0.
  - `daddr`, `dstore`, `dmemload` = 0 while the state is idle-and-invalid.
  - State = IDLE; hit counter = 0; `missed` = 0.
- Hit latency: 0 cycles (same cycle as the request).
- Clean miss: 1 + F cycles to `dhit`, where F = FILL cycles (at least 1).
- Dirty miss: W + F + 1 cycles, where W = WB cycles.
- `nRST` asserted mid-operation: immediate return to reset values. Bus requests drop asynchronously; dirty data is discarded.
- Flush of all-clean frames with the counter disabled: `flushed` rises NFRAMES+1 cycles after `halt` is sampled in IDLE.

## Configuration
- `DCACHE_HITCNT_EN` defined:
  - CNT state: `dWEN`=1, `daddr` = `HITCNT_ADDR`, `dstore` = hit counter.
  - Completes on `dwait`=0, then goes to DONE.
- Not defined: the counter logic and the CNT state are absent; FLUSH goes straight to DONE.

## Test plan
- Cold read of 0x40, memory returns 0xDEADBEEF after 2 `dwait` cycles:
  - `dREN`=1 and `daddr`=0x40 for 3 cycles.
  - `dhit`=1 with `dmemload`=0xDEADBEEF on the next cycle.
  - A repeat read hits in 0 cycles.
- Store 0x1234 to 0x40 (hit), then read 0x80 (same index, different tag):
  - WB: `dWEN`=1, `daddr`=0x40, `dstore`=0x1234.
  - Then FILL: `daddr`=0x80.
  - Then `dhit`.
- Store miss to 0x100, then read 0x100:
  - Sequence is fill, then `dhit` with the frame dirty.
  - The read returns the stored value with no bus activity.
- `halt` with frames 3 and 9 dirty and `dwait`=0:
  - Exactly two `dWEN` writes, to the addresses of frames 3 and 9.
  - Then the 0x3100 write when the macro is enabled.
  - Then `flushed`=1 and it stays high.
- Hit counter check, macro enabled: 3 first-try hits plus 1 miss-then-hit, then `halt` → write to 0x3100 with `dstore`=3.
- `nRST` low during FILL with `dwait`=1 → `dREN`=0 immediately; after release, the previously valid address misses.

Source files
------------

// File: rtl/dcache_wb_if.sv
// Pipeline-side and memory-side signals of the write-back data cache.
// slave = the cache's view, master = the pipeline/memory environment's view.
`timescale 1ns/1ps
interface dcache_wb_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_wb.sv
// Blocking direct-mapped write-back/write-allocate data cache with halt-time flush.
// Define DCACHE_HITCNT_EN to write the hit count to HITCNT_ADDR at the end of the flush.
`timescale 1ns/1ps
module dcache_wb #(
  parameter int          NFRAMES     = 16,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input logic        CLK,
  input logic        nRST,
  dcache_wb_if.slave bus
);
  localparam int IW = $clog2(NFRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FLUSH,
    FLUSH_WB,
`ifdef DCACHE_HITCNT_EN
    CNT,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [NFRAMES-1:0] valid_reg;
  logic [NFRAMES-1:0] dirty_reg;
  logic [IW-1:0]     scan_reg;
  logic              dren_reg;
  logic              dwen_reg;
  logic [31:0]       daddr_reg;
  logic [31:0]       dstore_reg;
  logic              flushed_reg;
  logic [TW-1:0]     tag_mem  [NFRAMES];
  logic [31:0]       data_mem [NFRAMES];
`ifdef DCACHE_HITCNT_EN
  logic [31:0]       hitcnt_reg;
  logic              missed_reg;
`else
  localparam logic [31:0] unused_hitcnt_addr = HITCNT_ADDR;
`endif

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req;
  logic          hit;
  logic          idle_hit;
  logic          last_scan;
  logic [31:0]   victim_addr;
  logic [31:0]   scan_addr;
  logic [31:0]   fill_addr;
  logic          unused_addr_bits;

  // Values loaded into the bus registers when the scan runs off the last frame.
  state_t        fin_state;
  logic          fin_dwen;
  logic [31:0]   fin_daddr;
  logic [31:0]   fin_dstore;
  logic          fin_flushed;

  assign req_idx          = bus.dmemaddr[IW+1:2];
  assign req_tag          = bus.dmemaddr[31:IW+2];
  assign req              = bus.dmemREN | bus.dmemWEN;
  assign hit              = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign idle_hit         = (state == IDLE) && !bus.halt && req && hit;
  assign last_scan        = (scan_reg == IW'(NFRAMES - 1));
  assign victim_addr      = {tag_mem[req_idx], req_idx, 2'b00};
  assign scan_addr        = {tag_mem[scan_reg], scan_reg, 2'b00};
  assign fill_addr        = {bus.dmemaddr[31:2], 2'b00};
  assign unused_addr_bits = ^bus.dmemaddr[1:0];

  always_comb begin
`ifdef DCACHE_HITCNT_EN
    fin_state   = CNT;
    fin_dwen    = 1'b1;
    fin_daddr   = HITCNT_ADDR;
    fin_dstore  = hitcnt_reg;
    fin_flushed = 1'b0;
`else
    fin_state   = DONE;
    fin_dwen    = 1'b0;
    fin_daddr   = '0;
    fin_dstore  = '0;
    fin_flushed = 1'b1;
`endif
  end

  assign bus.dhit     = idle_hit;
  assign bus.dmemload = ((state == IDLE) && hit) ? data_mem[req_idx] : '0;
  assign bus.dREN     = dren_reg;
  assign bus.dWEN     = dwen_reg;
  assign bus.daddr    = daddr_reg;
  assign bus.dstore   = dstore_reg;
  assign bus.flushed  = flushed_reg;

  // Tag and data carry no reset: only valid/dirty decide whether they matter.
  always_ff @(posedge CLK) begin
    if (idle_hit && bus.dmemWEN) begin
      data_mem[req_idx] <= bus.dmemstore;
    end else if ((state == FILL) && !bus.dwait) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus.dload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      valid_reg   <= '0;
      dirty_reg   <= '0;
      scan_reg    <= '0;
      dren_reg    <= 1'b0;
      dwen_reg    <= 1'b0;
      daddr_reg   <= '0;
      dstore_reg  <= '0;
      flushed_reg <= 1'b0;
`ifdef DCACHE_HITCNT_EN
      hitcnt_reg  <= '0;
      missed_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.halt) begin
            state    <= FLUSH;
            scan_reg <= '0;
          end else if (req) begin
            if (hit) begin
              if (bus.dmemWEN) dirty_reg[req_idx] <= 1'b1;
`ifdef DCACHE_HITCNT_EN
              if (!missed_reg) hitcnt_reg <= hitcnt_reg + 32'd1;
              missed_reg <= 1'b0;
`endif
            end else begin
`ifdef DCACHE_HITCNT_EN
              missed_reg <= 1'b1;
`endif
              if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
                state      <= WB;
                dwen_reg   <= 1'b1;
                daddr_reg  <= victim_addr;
                dstore_reg <= data_mem[req_idx];
              end else begin
                state     <= FILL;
                dren_reg  <= 1'b1;
                daddr_reg <= fill_addr;
              end
            end
          end
        end
        WB: begin
          if (!bus.dwait) begin
            dirty_reg[req_idx] <= 1'b0;
            state      <= FILL;
            dwen_reg   <= 1'b0;
            dstore_reg <= '0;
            dren_reg   <= 1'b1;
            daddr_reg  <= fill_addr;
          end
        end
        FILL: begin
          if (!bus.dwait) begin
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
            state     <= IDLE;
            dren_reg  <= 1'b0;
            daddr_reg <= '0;
          end
        end
        FLUSH: begin
          if (valid_reg[scan_reg] && dirty_reg[scan_reg]) begin
            state      <= FLUSH_WB;
            dwen_reg   <= 1'b1;
            daddr_reg  <= scan_addr;
            dstore_reg <= data_mem[scan_reg];
          end else if (last_scan) begin
            state       <= fin_state;
            dwen_reg    <= fin_dwen;
            daddr_reg   <= fin_daddr;
            dstore_reg  <= fin_dstore;
            flushed_reg <= fin_flushed;
          end else begin
            scan_reg <= scan_reg + 1'b1;
          end
        end
        FLUSH_WB: begin
          if (!bus.dwait) begin
            dirty_reg[scan_reg] <= 1'b0;
            if (last_scan) begin
              state       <= fin_state;
              dwen_reg    <= fin_dwen;
              daddr_reg   <= fin_daddr;
              dstore_reg  <= fin_dstore;
              flushed_reg <= fin_flushed;
            end else begin
              state      <= FLUSH;
              scan_reg   <= scan_reg + 1'b1;
              dwen_reg   <= 1'b0;
              daddr_reg  <= '0;
              dstore_reg <= '0;
            end
          end
        end
`ifdef DCACHE_HITCNT_EN
        CNT: begin
          if (!bus.dwait) begin
            state       <= DONE;
            dwen_reg    <= 1'b0;
            daddr_reg   <= '0;
            dstore_reg  <= '0;
            flushed_reg <= 1'b1;
          end
        end
`endif
        DONE: begin
          flushed_reg <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: vector table for hits/misses, hand sequences
// for flush, hit count (DCACHE_HITCNT_EN) and asynchronous reset during a fill.
`timescale 1ns/1ps
module tb_dcache_wb;
`ifdef DCACHE_HITCNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  dcache_wb_if bus();

  dcache_wb #(.NFRAMES(16), .HITCNT_ADDR(32'h0000_3100)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  // Memory model: wait_cfg busy cycles at the start of every access.
  logic [31:0] mem [0:4095];
  int          wait_cfg = 0;
  int          busy_cnt;
  int          ren_cycles = 0;
  logic [31:0] last_ren_addr = '0;
  logic        both_seen = 1'b0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  assign bus.dwait = (bus.dREN || bus.dWEN) && (busy_cnt < wait_cfg);
  assign bus.dload = mem[bus.daddr[13:2]];

  always @(posedge clk or negedge nrst) begin
    if (!nrst)                        busy_cnt <= 0;
    else if (bus.dREN || bus.dWEN)    busy_cnt <= bus.dwait ? busy_cnt + 1 : 0;
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (bus.dREN) begin
          ren_cycles++;
          last_ren_addr = bus.daddr;
        end
        if (bus.dREN && bus.dWEN) both_seen = 1'b1;
        if (bus.dWEN && !bus.dwait) begin
          mem[bus.daddr[13:2]] = bus.dstore;
          wr_addr_q.push_back(bus.daddr);
          wr_data_q.push_back(bus.dstore);
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_load, input int exp_lat, input int exp_nwr,
                        input string name);
    int lat;
    int wr0;
    logic [31:0] exp;
    wr0 = wr_addr_q.size();
    @(negedge clk);
    bus.dmemREN   = !we;
    bus.dmemWEN   = we;
    bus.dmemaddr  = addr;
    bus.dmemstore = wdata;
    if (!we) exp_q.push_back(exp_load);
    lat = 0;
    #1;
    while (!bus.dhit && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!bus.dhit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no dhit, required dhit within 100 cycles", name);
      if (!we) exp = exp_q.pop_front();
    end else begin
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      if (!we) begin
        exp = exp_q.pop_front();
        chk({name, " load"}, bus.dmemload, exp);
      end
    end
    @(posedge clk);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    chk({name, " mem writes"}, 32'(wr_addr_q.size() - wr0), 32'(exp_nwr));
    $display("txn %s %s addr=%h lat=%0d", name, we ? "st" : "ld", addr, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst        = 1'b0;
    bus.halt    = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic run_flush(output int cycles);
    @(negedge clk);
    bus.halt = 1'b1;
    cycles = 0;
    while (!bus.flushed && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (!bus.flushed) begin
      checks++;
      errors++;
      $display("FAIL flush timeout: got flushed=0, required 1 within 200 cycles");
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_load;
    int          exp_lat;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cyc;
    int wr0;
    int ren0;

    vecs[0]  = '{1'b0, 32'h040, 32'h0,         32'h0000_1234, 3, 1};
    vecs[1]  = '{1'b0, 32'h104, 32'h0,         32'h1000_0041, 2, 0};
    vecs[2]  = '{1'b1, 32'h104, 32'hAAAA_0001, 32'h0,         0, 0};
    vecs[3]  = '{1'b0, 32'h104, 32'h0,         32'hAAAA_0001, 0, 0};
    vecs[4]  = '{1'b0, 32'h144, 32'h0,         32'h1000_0051, 3, 1};
    vecs[5]  = '{1'b0, 32'h104, 32'h0,         32'hAAAA_0001, 2, 0};
    vecs[6]  = '{1'b0, 32'h108, 32'h0,         32'h1000_0042, 2, 0};
    vecs[7]  = '{1'b1, 32'h20C, 32'h0000_0033, 32'h0,         2, 0};
    vecs[8]  = '{1'b1, 32'h224, 32'h0000_0099, 32'h0,         2, 0};
    vecs[9]  = '{1'b0, 32'h20C, 32'h0,         32'h0000_0033, 0, 0};
    vecs[10] = '{1'b0, 32'h3FC, 32'h0,         32'h1000_00FF, 2, 0};

    nrst = 1'b0;
    bus.halt = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    #12;
    chk("reset dhit",     32'(bus.dhit),    32'd0);
    chk("reset dREN",     32'(bus.dREN),    32'd0);
    chk("reset dWEN",     32'(bus.dWEN),    32'd0);
    chk("reset flushed",  32'(bus.flushed), 32'd0);
    chk("reset daddr",    bus.daddr,        32'd0);
    chk("reset dstore",   bus.dstore,       32'd0);
    chk("reset dmemload", bus.dmemload,     32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // All-clean flush timing straight out of reset.
    wr0 = wr_addr_q.size();
    run_flush(cyc);
    chk("clean flush cycles", 32'(cyc), 32'(17 + CNT_ON));
    chk("clean flush writes", 32'(wr_addr_q.size() - wr0), 32'(CNT_ON));
    do_reset();

    // Cold read with two busy cycles, then a zero-latency repeat.
    wait_cfg = 2;
    ren0 = ren_cycles;
    do_req(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 4, 0, "cold_rd40");
    chk("cold fill dREN cycles", 32'(ren_cycles - ren0), 32'd3);
    chk("cold fill daddr", last_ren_addr, 32'h40);
    wait_cfg = 0;
    do_req(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 0, "rehit_rd40");

    // Dirty victim written back before the conflicting fill.
    wr0 = wr_addr_q.size();
    do_req(1'b1, 32'h40, 32'h1234, 32'h0, 0, 0, "st40");
    do_req(1'b0, 32'h80, 32'h0, 32'h1000_0020, 3, 1, "rd80_dirty");
    chk("wb addr", (wr_addr_q.size() > wr0) ? wr_addr_q[wr0] : 32'hFFFF_FFFF, 32'h40);
    chk("wb data", (wr_data_q.size() > wr0) ? wr_data_q[wr0] : 32'hFFFF_FFFF, 32'h1234);
    chk("refill daddr", last_ren_addr, 32'h80);

    // Write-allocate, then the read is served from the cache.
    do_req(1'b1, 32'h100, 32'h77, 32'h0, 2, 0, "st100_miss");
    ren0 = ren_cycles;
    do_req(1'b0, 32'h100, 32'h0, 32'h77, 0, 0, "rd100");
    chk("rd100 bus idle", 32'(ren_cycles - ren0), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_load,
             vecs[i].exp_lat, vecs[i].exp_nwr, $sformatf("vec%0d", i));
    end

    // Frames 3 and 9 are the only dirty ones.
    wr0 = wr_addr_q.size();
    run_flush(cyc);
    chk("flush1 writes", 32'(wr_addr_q.size() - wr0), 32'(2 + CNT_ON));
    chk("flush1 wr0 addr", (wr_addr_q.size() > wr0) ? wr_addr_q[wr0] : 32'hFFFF_FFFF, 32'h20C);
    chk("flush1 wr0 data", (wr_data_q.size() > wr0) ? wr_data_q[wr0] : 32'hFFFF_FFFF, 32'h33);
    chk("flush1 wr1 addr", (wr_addr_q.size() > wr0 + 1) ? wr_addr_q[wr0+1] : 32'hFFFF_FFFF, 32'h224);
    chk("flush1 wr1 data", (wr_data_q.size() > wr0 + 1) ? wr_data_q[wr0+1] : 32'hFFFF_FFFF, 32'h99);
`ifdef DCACHE_HITCNT_EN
    chk("flush1 cnt addr", (wr_addr_q.size() > wr0 + 2) ? wr_addr_q[wr0+2] : 32'hFFFF_FFFF, 32'h3100);
    chk("flush1 cnt data", (wr_data_q.size() > wr0 + 2) ? wr_data_q[wr0+2] : 32'hFFFF_FFFF, 32'd6);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("flushed sticky", 32'(bus.flushed), 32'd1);
      chk("done bus idle", 32'(bus.dREN | bus.dWEN), 32'd0);
    end
    do_reset();

    // Hit counter: one miss-then-hit and three first-try hits.
    do_req(1'b0, 32'h40, 32'h0, 32'h0000_1234, 2, 0, "hc_miss");
    do_req(1'b0, 32'h40, 32'h0, 32'h0000_1234, 0, 0, "hc_hit1");
    do_req(1'b0, 32'h40, 32'h0, 32'h0000_1234, 0, 0, "hc_hit2");
    do_req(1'b1, 32'h40, 32'h5555, 32'h0, 0, 0, "hc_hit3");
    wr0 = wr_addr_q.size();
    run_flush(cyc);
    chk("flush2 writes", 32'(wr_addr_q.size() - wr0), 32'(1 + CNT_ON));
    chk("flush2 wr0 data", (wr_data_q.size() > wr0) ? wr_data_q[wr0] : 32'hFFFF_FFFF, 32'h5555);
`ifdef DCACHE_HITCNT_EN
    chk("flush2 cnt addr", (wr_addr_q.size() > wr0 + 1) ? wr_addr_q[wr0+1] : 32'hFFFF_FFFF, 32'h3100);
    chk("flush2 cnt data", (wr_data_q.size() > wr0 + 1) ? wr_data_q[wr0+1] : 32'hFFFF_FFFF, 32'd3);
`endif
    do_reset();

    // Asynchronous reset while a fill is stalled.
    do_req(1'b0, 32'h44, 32'h0, 32'h1000_0011, 2, 0, "pre_rst_rd44");
    wait_cfg = 5;
    @(negedge clk);
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h84;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("fill dREN before reset", 32'(bus.dREN), 32'd1);
    nrst = 1'b0;
    #1;
    chk("async reset dREN", 32'(bus.dREN), 32'd0);
    chk("async reset daddr", bus.daddr, 32'd0);
    chk("async reset dhit", 32'(bus.dhit), 32'd0);
    bus.dmemREN = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    nrst = 1'b1;
    do_req(1'b0, 32'h44, 32'h0, 32'h1000_0011, 2, 0, "post_rst_rd44");

    chk("dREN/dWEN overlap", 32'(both_seen), 32'd0);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
